// File: rtl/spd_info_frame_receiver_if.sv
// Byte-stream input and decoded-field output bundle of the SPD InfoFrame receiver.
// The master drives packet bytes; the slave, the receiver itself, publishes the fields.
interface spd_info_frame_receiver_if;
  logic         pkt_start;
  logic         byte_valid;
  logic [7:0]   byte_data;
  logic [63:0]  vendor_name;
  logic [127:0] product_description;
  logic [7:0]   source_device_information;
  logic         spd_valid;
  logic         spd_update;
  logic         checksum_error;
  logic         format_error;

  modport master (
    output pkt_start, byte_valid, byte_data,
    input  vendor_name, product_description, source_device_information,
    input  spd_valid, spd_update, checksum_error, format_error
  );

  modport slave (
    input  pkt_start, byte_valid, byte_data,
    output vendor_name, product_description, source_device_information,
    output spd_valid, spd_update, checksum_error, format_error
  );
endinterface

// File: rtl/spd_info_frame_receiver.sv
// Recognises SPD InfoFrames in the decoded data-island byte stream, checks header and checksum,
// and publishes vendor, product and source-device fields atomically on each good frame.
module spd_info_frame_receiver #(
  parameter int         RESTORE_PAD    = 1,
  parameter logic [7:0] EXPECT_VERSION = 8'd1
) (
  input  logic                      clk_pixel,
  input  logic                      rst_n,
  spd_info_frame_receiver_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HEADER, BODY, DISCARD} state_t;

  state_t       state_q, state_d;
  logic [4:0]   idx_q, idx_d;
  logic [7:0]   sum_q, sum_d;
  logic [63:0]  vendorShadow_q, vendorShadow_d;
  logic [127:0] productShadow_q, productShadow_d;
  logic [7:0]   sdiShadow_q, sdiShadow_d;
  logic [63:0]  vendor_q, vendor_d;
  logic [127:0] product_q, product_d;
  logic [7:0]   sdi_q, sdi_d;
  logic         spdValid_q, spdValid_d;
  logic         spdUpdate_q, spdUpdate_d;
  logic         checksumError_q, checksumError_d;
  logic         formatError_q, formatError_d;
  logic [7:0]   padByte;

  assign padByte = ((RESTORE_PAD != 0) && (bus.byte_data == 8'h00)) ? 8'h30 : bus.byte_data;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      sum_q           <= '0;
      vendorShadow_q  <= '0;
      productShadow_q <= '0;
      sdiShadow_q     <= '0;
      vendor_q        <= '0;
      product_q       <= '0;
      sdi_q           <= '0;
      spdValid_q      <= 1'b0;
      spdUpdate_q     <= 1'b0;
      checksumError_q <= 1'b0;
      formatError_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      sum_q           <= sum_d;
      vendorShadow_q  <= vendorShadow_d;
      productShadow_q <= productShadow_d;
      sdiShadow_q     <= sdiShadow_d;
      vendor_q        <= vendor_d;
      product_q       <= product_d;
      sdi_q           <= sdi_d;
      spdValid_q      <= spdValid_d;
      spdUpdate_q     <= spdUpdate_d;
      checksumError_q <= checksumError_d;
      formatError_q   <= formatError_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    sum_d           = sum_q;
    vendorShadow_d  = vendorShadow_q;
    productShadow_d = productShadow_q;
    sdiShadow_d     = sdiShadow_q;
    vendor_d        = vendor_q;
    product_d       = product_q;
    sdi_d           = sdi_q;
    spdValid_d      = spdValid_q;
    spdUpdate_d     = 1'b0;
    checksumError_d = 1'b0;
    formatError_d   = 1'b0;

    // A qualified pkt_start always restarts capture, silently dropping any frame in progress.
    if (bus.byte_valid && bus.pkt_start) begin
      idx_d   = 5'd1;
      sum_d   = bus.byte_data;
      state_d = (bus.byte_data == 8'h83) ? HEADER : DISCARD;
    end else if (bus.byte_valid) begin
      case (state_q)
        HEADER: begin
          idx_d = idx_q + 5'd1;
          sum_d = sum_q + bus.byte_data;
          if (idx_q == 5'd1) begin
            if (bus.byte_data != EXPECT_VERSION) begin
              formatError_d = 1'b1;
              state_d       = DISCARD;
            end
          end else if ((bus.byte_data[4:0] != 5'd25) || (bus.byte_data[7:5] != 3'd0)) begin
            formatError_d = 1'b1;
            state_d       = DISCARD;
          end else begin
            state_d = BODY;
          end
        end
        BODY: begin
          idx_d = idx_q + 5'd1;
          if (idx_q <= 5'd28) sum_d = sum_q + bus.byte_data;
          // PB1..PB8 sit at idx 4..11, PB9..PB24 at idx 12..27, PB25 at idx 28.
          for (int i = 0; i < 8; i++)
            if (idx_q == 5'(4 + i)) vendorShadow_d[63 - 8*i -: 8] = padByte;
          for (int i = 0; i < 16; i++)
            if (idx_q == 5'(12 + i)) productShadow_d[127 - 8*i -: 8] = padByte;
          if (idx_q == 5'd28) sdiShadow_d = bus.byte_data;
          if (idx_q == 5'd30) begin
            idx_d   = '0;
            state_d = IDLE;
            if (sum_q == 8'h00) begin
              vendor_d    = vendorShadow_q;
              product_d   = productShadow_q;
              sdi_d       = sdiShadow_q;
              spdValid_d  = 1'b1;
              spdUpdate_d = 1'b1;
            end else begin
              checksumError_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.vendor_name               = vendor_q;
  assign bus.product_description       = product_q;
  assign bus.source_device_information = sdi_q;
  assign bus.spd_valid                 = spdValid_q;
  assign bus.spd_update                = spdUpdate_q;
  assign bus.checksum_error            = checksumError_q;
  assign bus.format_error              = formatError_q;

endmodule
